fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC SHALL be 32-bit, default 32'h0040_0000, meaning first fetch address after reset.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 reset_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-004 imem_req_valid  output  1  SHALL flag a valid instruction-memory read request.
REQ-005 imem_req_ready  input  1  SHALL be memory acceptance of the request.
REQ-006 imem_addr  output  32  SHALL carry the fetch PC, bits [1:0] always 0.
REQ-007 imem_rsp_valid  input  1  SHALL flag returned instruction data.
REQ-008 imem_rsp_data  input  32  SHALL be the returned instruction word.
REQ-009 stall  input  1  SHALL mean decode cannot accept a new IF/ID entry this cycle.
REQ-010 redirect_valid  input  1  SHALL mean a taken branch was resolved; redirect fetch.
REQ-011 redirect_pc  input  32  SHALL be the branch target; bits [1:0] ignored and treated as 0.
REQ-012 if_id_valid  output  1  SHALL flag a valid IF/ID entry.
REQ-013 if_id_instr  output  32  SHALL be the registered instruction word.
REQ-014 if_id_pc4  output  32  SHALL be the fetched PC + 4.
REQ-015 if_id_op  output  6  SHALL equal if_id_instr[31:26], the opcode feeding the control decoder.

Function
REQ-016 FSM states SHALL be REQ (request driven), WAIT (request accepted, awaiting response), HOLD (response buffered while stalled).
REQ-017 In REQ, imem_req_valid SHALL be 1 and imem_addr = pc; on imem_req_ready the FSM SHALL go to WAIT; imem_req_valid SHALL be 0 in WAIT and HOLD.
REQ-018 At most one request SHALL be outstanding.
REQ-019 In WAIT, on imem_rsp_valid with squash=0 and (stall=0 or if_id_valid=0): load if_id_instr = rsp_data, if_id_pc4 = pc+4, if_id_valid = 1, pc <= pc+4, go to REQ.
REQ-020 In WAIT, on imem_rsp_valid with squash=0, stall=1, if_id_valid=1: capture rsp_data in a 1-entry buffer, go to HOLD.
REQ-021 In HOLD, when stall=0: load IF/ID from the buffer as in REQ-019, go to REQ; while stall=1, hold.
REQ-022 Without a new load, if_id_valid SHALL clear when stall=0 (entry consumed) and keep its value when stall=1; if_id_instr/if_id_pc4 SHALL hold when not loaded.
REQ-023 pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-024 redirect_valid SHALL take priority over stall and all loads: if_id_valid <= 0, pc <= {redirect_pc[31:2],2'b00}.
REQ-025 Redirect in REQ without imem_req_ready SHALL stay in REQ; with imem_req_ready the FSM SHALL go to WAIT with squash <= 1.
REQ-026 Redirect in WAIT SHALL set squash <= 1, unless imem_rsp_valid is also 1, in which case that response is dropped and the FSM goes to REQ.
REQ-027 Redirect in HOLD SHALL discard the buffer and go to REQ.
REQ-028 In WAIT with squash=1, a response SHALL be dropped, squash cleared, FSM to REQ; the next request uses the redirected pc.
REQ-029 Fetch latency: request accept to if_id_valid SHALL be response cycle + 1 when not stalled.

Reset
REQ-030 reset_n low SHALL asynchronously set pc = RESET_PC, state = REQ, squash = 0, if_id_valid = 0, if_id_instr = 0, if_id_pc4 = 0, buffer = 0.
REQ-031 Reset mid-request SHALL abandon any outstanding response; the first post-reset request is to RESET_PC.

Structure
REQ-032 Shared package SHALL hold the FSM state encoding, RESET_PC default, and NOP word 32'h0000_0000.
REQ-033 One sub-module, pc_reg (32-bit async-reset register with load-enable and reset value), SHALL hold the PC; all else inline.

Verification
REQ-034 Reset release, ready=1, rsp 1 cycle later = 32'h2008_0005 -> imem_addr 32'h0040_0000, if_id_op = 6'b001000, if_id_pc4 = 32'h0040_0004.
REQ-035 stall=1 with if_id_valid=1 during response 32'h8C01_0000 -> HOLD, IF/ID unchanged; stall drop -> if_id_instr = 32'h8C01_0000 next cycle.
REQ-036 redirect_pc = 32'h0040_0103 while in WAIT -> stale response dropped, if_id_valid = 0, next imem_addr = 32'h0040_0100.
REQ-037 redirect and stall asserted together in HOLD -> buffer discarded, if_id_valid = 0, FSM in REQ.
REQ-038 pc = 32'hFFFF_FFFC fetch -> if_id_pc4 = 32'h0000_0000, next imem_addr = 32'h0000_0000.
REQ-039 reset_n pulsed low in WAIT, late response arrives after release -> ignored, imem_addr = RESET_PC.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction fetch stage.
package fetch_stage_pkg;

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  localparam logic [31:0] RESET_PC_DEF = 32'h0040_0000;
  localparam logic [31:0] NOP_WORD     = 32'h0000_0000;

endpackage

// File: rtl/fetch_stage_pc_reg.sv
// Program counter register: async active-low reset, load enable.
module pc_reg #(
  parameter logic [31:0] RESET_VAL = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load,
  input  logic [31:0] d,
  output logic [31:0] q
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      q <= RESET_VAL;
    else if (load)
      q <= d;
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: one outstanding imem request, 1-entry stall buffer.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_id_valid,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic [5:0]  if_id_op
);

  state_t      state;
  logic        squash;
  logic [31:0] rsp_buf;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] pc_next;
  logic        pc_load;
  logic        unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^redirect_pc[1:0];
  assign pc_plus4 = pc + 32'd4;

  pc_reg #(
    .RESET_VAL(RESET_PC)
  ) u_pc_reg (
    .clk    (clk),
    .reset_n(reset_n),
    .load   (pc_load),
    .d      (pc_next),
    .q      (pc)
  );

  // The PC advances exactly when an IF/ID load happens; a redirect overrides it.
  always_comb begin
    pc_load = 1'b0;
    pc_next = pc_plus4;
    if (redirect_valid) begin
      pc_load = 1'b1;
      pc_next = {redirect_pc[31:2], 2'b00};
    end else if (state == ST_WAIT && imem_rsp_valid && !squash && (!stall || !if_id_valid)) begin
      pc_load = 1'b1;
    end else if (state == ST_HOLD && !stall) begin
      pc_load = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_REQ;
      squash      <= 1'b0;
      rsp_buf     <= NOP_WORD;
      if_id_valid <= 1'b0;
      if_id_instr <= NOP_WORD;
      if_id_pc4   <= '0;
    end else if (redirect_valid) begin
      if_id_valid <= 1'b0;
      case (state)
        ST_REQ: begin
          if (imem_req_ready) begin
            state  <= ST_WAIT;
            squash <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (imem_rsp_valid) begin
            state  <= ST_REQ;
            squash <= 1'b0;
          end else begin
            squash <= 1'b1;
          end
        end
        default: begin
          state   <= ST_REQ;
          rsp_buf <= NOP_WORD;
        end
      endcase
    end else begin
      if (!stall)
        if_id_valid <= 1'b0;
      case (state)
        ST_REQ: begin
          if (imem_req_ready)
            state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (imem_rsp_valid) begin
            if (squash) begin
              squash <= 1'b0;
              state  <= ST_REQ;
            end else if (!stall || !if_id_valid) begin
              if_id_valid <= 1'b1;
              if_id_instr <= imem_rsp_data;
              if_id_pc4   <= pc_plus4;
              state       <= ST_REQ;
            end else begin
              rsp_buf <= imem_rsp_data;
              state   <= ST_HOLD;
            end
          end
        end
        default: begin
          if (!stall) begin
            if_id_valid <= 1'b1;
            if_id_instr <= rsp_buf;
            if_id_pc4   <= pc_plus4;
            state       <= ST_REQ;
          end
        end
      endcase
    end
  end

  assign imem_req_valid = (state == ST_REQ);
  assign imem_addr      = pc;
  assign if_id_op       = if_id_instr[31:26];

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  logic        clk;
  logic        reset_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_id_valid;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;
  logic [5:0]  if_id_op;

  int unsigned n_tests;
  int unsigned n_fail;

  fetch_stage #(
    .RESET_PC(32'h0040_0000)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_addr     (imem_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .stall         (stall),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .if_id_valid   (if_id_valid),
    .if_id_instr   (if_id_instr),
    .if_id_pc4     (if_id_pc4),
    .if_id_op      (if_id_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_tests        = 0;
    n_fail         = 0;
    reset_n        = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;

    // reset state
    tick();
    tick();
    check("rst_valid",   32'(if_id_valid), 32'd0);
    check("rst_instr",   if_id_instr, 32'h0);
    check("rst_pc4",     if_id_pc4, 32'h0);
    check("rst_reqv",    32'(imem_req_valid), 32'd1);
    check("rst_addr",    imem_addr, 32'h0040_0000);
    reset_n = 1'b1;

    // basic fetch
    imem_req_ready = 1'b1;
    #1;
    check("f1_addr", imem_addr, 32'h0040_0000);
    tick();
    imem_req_ready = 1'b0;
    check("f1_wait_reqv", 32'(imem_req_valid), 32'd0);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h2008_0005;
    tick();
    imem_rsp_valid = 1'b0;
    check("f1_valid", 32'(if_id_valid), 32'd1);
    check("f1_op",    32'(if_id_op), 32'h08);
    check("f1_instr", if_id_instr, 32'h2008_0005);
    check("f1_pc4",   if_id_pc4, 32'h0040_0004);
    check("f1_addr2", imem_addr, 32'h0040_0004);
    check("f1_reqv2", 32'(imem_req_valid), 32'd1);

    // stall during response -> HOLD, then release
    stall          = 1'b1;
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h8C01_0000;
    tick();
    imem_rsp_valid = 1'b0;
    check("h_valid", 32'(if_id_valid), 32'd1);
    check("h_instr", if_id_instr, 32'h2008_0005);
    check("h_reqv",  32'(imem_req_valid), 32'd0);
    tick();
    check("h_instr2", if_id_instr, 32'h2008_0005);
    check("h_pc4",    if_id_pc4, 32'h0040_0004);
    stall = 1'b0;
    tick();
    check("h_rel_instr", if_id_instr, 32'h8C01_0000);
    check("h_rel_pc4",   if_id_pc4, 32'h0040_0008);
    check("h_rel_valid", 32'(if_id_valid), 32'd1);
    check("h_rel_addr",  imem_addr, 32'h0040_0008);
    tick();
    check("consumed_valid", 32'(if_id_valid), 32'd0);
    check("consumed_instr", if_id_instr, 32'h8C01_0000);

    // redirect while waiting
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0040_0103;
    tick();
    redirect_valid = 1'b0;
    check("rw_reqv", 32'(imem_req_valid), 32'd0);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hDEAD_BEEF;
    tick();
    imem_rsp_valid = 1'b0;
    check("rw_valid", 32'(if_id_valid), 32'd0);
    check("rw_addr",  imem_addr, 32'h0040_0100);
    check("rw_reqv2", 32'(imem_req_valid), 32'd1);
    check("rw_instr", if_id_instr, 32'h8C01_0000);

    // redirect + stall together in HOLD
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h1111_1111;
    tick();
    imem_rsp_valid = 1'b0;
    check("rh_pre_instr", if_id_instr, 32'h1111_1111);
    stall          = 1'b1;
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h2222_2222;
    tick();
    imem_rsp_valid = 1'b0;
    check("rh_hold_reqv", 32'(imem_req_valid), 32'd0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0010;
    tick();
    redirect_valid = 1'b0;
    check("rh_valid", 32'(if_id_valid), 32'd0);
    check("rh_reqv",  32'(imem_req_valid), 32'd1);
    check("rh_addr",  imem_addr, 32'h0000_0010);
    check("rh_instr", if_id_instr, 32'h1111_1111);
    stall = 1'b0;
    tick();
    check("rh_still_req", 32'(imem_req_valid), 32'd1);
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h3333_3333;
    tick();
    imem_rsp_valid = 1'b0;
    check("rh_next_instr", if_id_instr, 32'h3333_3333);
    check("rh_next_pc4",   if_id_pc4, 32'h0000_0014);

    // PC wrap at top of address space; redirect in REQ without ready
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    check("wr_addr", imem_addr, 32'hFFFF_FFFC);
    check("wr_reqv", 32'(imem_req_valid), 32'd1);
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h4444_4444;
    tick();
    imem_rsp_valid = 1'b0;
    check("wr_pc4",   if_id_pc4, 32'h0000_0000);
    check("wr_addr2", imem_addr, 32'h0000_0000);
    check("wr_valid", 32'(if_id_valid), 32'd1);

    // redirect in REQ with ready: request goes out but its response is squashed
    imem_req_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0200;
    tick();
    imem_req_ready = 1'b0;
    redirect_valid = 1'b0;
    check("rq_reqv",  32'(imem_req_valid), 32'd0);
    check("rq_valid", 32'(if_id_valid), 32'd0);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h5555_5555;
    tick();
    imem_rsp_valid = 1'b0;
    check("rq_addr",  imem_addr, 32'h0000_0200);
    check("rq_instr", if_id_instr, 32'h4444_4444);
    check("rq_valid2", 32'(if_id_valid), 32'd0);

    // reset pulse while waiting; late response ignored
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    reset_n = 1'b0;
    #2;
    check("ar_addr",  imem_addr, 32'h0040_0000);
    check("ar_reqv",  32'(imem_req_valid), 32'd1);
    check("ar_instr", if_id_instr, 32'h0);
    reset_n = 1'b1;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h6666_6666;
    tick();
    imem_rsp_valid = 1'b0;
    check("ar_late_valid", 32'(if_id_valid), 32'd0);
    check("ar_late_addr",  imem_addr, 32'h0040_0000);
    check("ar_late_reqv",  32'(imem_req_valid), 32'd1);
    check("ar_late_instr", if_id_instr, 32'h0);
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h7777_7777;
    tick();
    imem_rsp_valid = 1'b0;
    check("ar_new_instr", if_id_instr, 32'h7777_7777);
    check("ar_new_pc4",   if_id_pc4, 32'h0040_0004);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
